// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - AXI4 subordinate backed by on-chip block RAM (64-bit, INCR/FIXED)
// One transaction in flight; reads stream through a single registered RAM stage.
module axi_mem_responder #(
  parameter int          ID_WIDTH   = 6,
  parameter int          ADDR_WIDTH = 27,
  parameter logic [31:0] MEM_SIZE   = 32'h10000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  o_init_done,
  input  logic [ID_WIDTH-1:0]   i_awid,
  input  logic [ADDR_WIDTH-1:0] i_awaddr,
  input  logic [7:0]            i_awlen,
  input  logic [2:0]            i_awsize,
  input  logic [1:0]            i_awburst,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  input  logic [ID_WIDTH-1:0]   i_arid,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  input  logic [7:0]            i_arlen,
  input  logic [2:0]            i_arsize,
  input  logic [1:0]            i_arburst,
  input  logic                  i_arvalid,
  output logic                  o_arready,
  input  logic [63:0]           i_wdata,
  input  logic [7:0]            i_wstrb,
  input  logic                  i_wlast,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [ID_WIDTH-1:0]   o_bid,
  output logic [1:0]            o_bresp,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  output logic [ID_WIDTH-1:0]   o_rid,
  output logic [63:0]           o_rdata,
  output logic [1:0]            o_rresp,
  output logic                  o_rlast,
  output logic                  o_rvalid,
  input  logic                  i_rready
);

  localparam int         DEPTH  = int'(MEM_SIZE >> 3);
  localparam int         IW     = $clog2(DEPTH);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WRESP, S_READ} state_t;

  logic [63:0]           mem [DEPTH];
  logic [63:0]           rd_q;
  state_t                state, state_n;
  logic                  rr_read;
  logic [ID_WIDTH-1:0]   txn_id;
  logic [ADDR_WIDTH-1:0] addr, addr_next;
  logic [7:0]            len;
  logic [2:0]            size;
  logic [1:0]            burst;
  logic [8:0]            beat_cnt;
  logic [1:0]            resp_acc, beat_resp, wr_resp;
  logic                  in_range, last_cnt, aw_hs, ar_hs, w_hs, we, rd_en;
  logic                  r_valid, r_last;
  logic [1:0]            r_resp;

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign addr_next = (burst == 2'b00) ? addr : addr + (ADDR_WIDTH'(1) << size);
  assign in_range  = ({{(64-ADDR_WIDTH){1'b0}}, addr} < 64'(MEM_SIZE));
  assign last_cnt  = (beat_cnt == {1'b0, len});
  // burst[1] covers WRAP and the reserved encoding
  assign beat_resp = burst[1] ? SLVERR : (in_range ? OKAY : DECERR);
  assign wr_resp   = worst(worst(resp_acc, beat_resp), (i_wlast != last_cnt) ? SLVERR : OKAY);

  assign aw_hs = i_awvalid && o_awready;
  assign ar_hs = i_arvalid && o_arready;
  assign w_hs  = i_wvalid && o_wready;
  assign we    = w_hs && (beat_resp == OKAY);

  assign o_bvalid = (state == S_WRESP);
  assign o_bid    = txn_id;
  assign o_rid    = txn_id;
  assign o_rvalid = r_valid;
  assign o_rresp  = r_resp;
  assign o_rlast  = r_last;
  assign o_rdata  = (r_valid && r_resp == OKAY) ? rd_q : 64'd0;

  always_comb begin
    state_n   = state;
    o_awready = 1'b0;
    o_arready = 1'b0;
    o_wready  = 1'b0;
    rd_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (o_init_done && !rst) begin
          o_arready = i_arvalid && (!i_awvalid || rr_read);
          o_awready = i_awvalid && !o_arready;
        end
        if (ar_hs)      state_n = S_READ;
        else if (aw_hs) state_n = S_WDATA;
      end
      S_WDATA: begin
        o_wready = !rst;
        if (w_hs && (i_wlast || last_cnt)) state_n = S_WRESP;
      end
      S_WRESP: if (i_bready) state_n = S_IDLE;
      S_READ: begin
        // RAM is only read when the output register is free or draining this cycle
        rd_en = (beat_cnt <= {1'b0, len}) && (!r_valid || i_rready);
        if (r_valid && i_rready && r_last) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      o_init_done <= 1'b0;
      rr_read     <= 1'b1;
      txn_id      <= '0;
      addr        <= '0;
      len         <= '0;
      size        <= '0;
      burst       <= '0;
      beat_cnt    <= '0;
      resp_acc    <= OKAY;
      o_bresp     <= OKAY;
      r_valid     <= 1'b0;
      r_resp      <= OKAY;
      r_last      <= 1'b0;
    end else begin
      state       <= state_n;
      o_init_done <= 1'b1;
      if (ar_hs) begin
        {txn_id, addr, len, size, burst} <= {i_arid, i_araddr, i_arlen, i_arsize, i_arburst};
        beat_cnt <= '0;
        rr_read  <= 1'b0;
      end else if (aw_hs) begin
        {txn_id, addr, len, size, burst} <= {i_awid, i_awaddr, i_awlen, i_awsize, i_awburst};
        beat_cnt <= '0;
        resp_acc <= OKAY;
        rr_read  <= 1'b1;
      end
      if (w_hs) begin
        beat_cnt <= beat_cnt + 9'd1;
        addr     <= addr_next;
        resp_acc <= worst(resp_acc, beat_resp);
        if (i_wlast || last_cnt) o_bresp <= wr_resp;
      end
      if (rd_en) begin
        beat_cnt <= beat_cnt + 9'd1;
        addr     <= addr_next;
        r_valid  <= 1'b1;
        r_resp   <= beat_resp;
        r_last   <= last_cnt;
      end else if (r_valid && i_rready) begin
        r_valid  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (i_wstrb[b]) mem[addr[IW+2:3]][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (rd_en) rd_q <= mem[addr[IW+2:3]];
  end

endmodule
